i2c_target_regfile: RTL

Parametrised successor to the I2C slave controller: an I2C target sampled on a system clock instead of clocked by SCL, with a configurable 7-bit address and a NUM_REGS x 8-bit register file. Supports register-pointer addressing, multi-byte auto-increment reads and writes, repeated START and STOP recovery. Sits behind the pad open-drain buffers; exposes the registers to local logic.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_in_filter.sv | 55 +++++
 rtl/i2c_target_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the clk-sampled I2C target and its register file.
// Latency and backpressure: not applicable (declarations only).
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit positions inside the address byte sent after START.
  localparam int RW_BIT   = 0;
  localparam int ADDR_LSB = 1;
  localparam int ADDR_MSB = 7;

endpackage

// File: rtl/i2c_in_filter.sv
// SCL/SDA synchroniser, glitch filter and SCL-edge/START/STOP pulse generation.
// Latency: 2 sync + FILTER_LEN filter clks; backpressure: none, pulses are 1 clk wide.
module i2c_in_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  // Index 1 carries SCL, index 0 carries SDA.
  logic [1:0]         sync1, sync2, filt, filt_q;
  logic [1:0][CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      cnt    <= '0;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sda_f     = filt[0];
  assign scl_rise  =  filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] &  filt_q[1];
  // SCL must be high on both samples so an SCL edge never doubles as START/STOP.
  assign start_det = filt[1] & filt_q[1] &  filt_q[0] & ~filt[0];
  assign stop_det  = filt[1] & filt_q[1] & ~filt_q[0] &  filt[0];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target sampled on clk, exposing a NUM_REGS x 8 register file with pointer auto-increment.
// Latency: ~FILTER_LEN+3 clks from pad edge to action; backpressure: none (ACKs every matched byte).
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = 7'h2A,
  parameter int         NUM_REGS   = 8,
  parameter int         FILTER_LEN = 3,
  localparam int        IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic                  loc_wr_en,
  input  logic [IDX_W-1:0]      loc_wr_idx,
  input  logic [7:0]            loc_wr_data,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [IDX_W-1:0]      wr_idx,
  output logic                  busy
);

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_in_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t           state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n, rx_byte;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic             sda_oe_n, busy_n, rw, rw_n, i2c_we;
  logic [7:0]       regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 3'd7;
      shift   <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      rw      <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      ptr     <= ptr_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      rw      <= rw_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    rw_n      = rw;
    i2c_we    = 1'b0;
    rx_byte   = {shift[6:0], sda_f};

    if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd7;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n = rx_byte;
            if (bit_cnt == 3'd0) begin
              if (rx_byte[ADDR_MSB:ADDR_LSB] == I2C_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = rx_byte[RW_BIT];
              end else begin
                state_n = WAIT_STOP;
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
        end

        // First fall after the byte asserts ACK, the next one releases it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd7;
              if (state == ADDR_ACK && rw) begin
                state_n  = RDATA;
                shift_n  = regs[ptr];
                sda_oe_n = ~regs[ptr][7];
              end else if (state == ADDR_ACK) begin
                state_n = PTR;
              end else begin
                state_n = WDATA;
              end
            end
          end
        end

        PTR, WDATA: begin
          if (scl_rise) begin
            shift_n = rx_byte;
            if (bit_cnt == 3'd0) begin
              if (state == PTR) begin
                ptr_n   = rx_byte[IDX_W-1:0];
                state_n = PTR_ACK;
              end else begin
                i2c_we  = 1'b1;
                ptr_n   = ptr + 1'b1;
                state_n = WDATA_ACK;
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
        end

        // shift[7] is always the bit currently on the bus.
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe_n = 1'b0;
              state_n  = RDATA_ACK;
            end else begin
              shift_n   = {shift[6:0], 1'b0};
              sda_oe_n  = ~shift[6];
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr + 1'b1;
            if (sda_f == I2C_NACK) begin
              state_n = WAIT_STOP;
            end
          end else if (scl_fall) begin
            state_n   = RDATA;
            bit_cnt_n = 3'd7;
            shift_n   = regs[ptr];
            sda_oe_n  = ~regs[ptr][7];
          end
        end

        default: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
        end
      endcase
    end
  end

  // The I2C write is applied last so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
      wr_strobe <= 1'b0;
      wr_idx    <= '0;
    end else begin
      if (loc_wr_en) begin
        regs[loc_wr_idx] <= loc_wr_data;
      end
      if (i2c_we) begin
        regs[ptr] <= rx_byte;
        wr_idx    <= ptr;
      end
      wr_strobe <= i2c_we;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = regs[k];
  end

endmodule
